// File: rtl/tm1638_frame_arbiter.sv
// tm1638_frame_arbiter: two-client ownership arbiter for a TM1638 display.
// Grants the display to requester A or B, holds a contested owner for at
// least HOLD_CYCLES clocks, muxes the owner's digits/LEDs to the driver, and
// routes debounced key-press pulses to the current owner only.
//
// Ports:
//   clk_5MHz, n_rst          - clock, asynchronous active-low reset
//   req_a/req_b              - ownership requests (level)
//   frame_a/frame_b [63:0]   - digit1 in [63:56] .. digit8 in [7:0]
//   leds_a/leds_b   [15:0]   - {green[7:0], red[7:0]}
//   keys_raw        [7:0]    - raw key vector from the display driver
//   digits, leds_green, leds_red, display_off - owner's display data
//   grant           [1:0]    - {b,a}, registered, one-hot or zero
//   keys_a_evt/keys_b_evt    - one-cycle key-press pulses to the owner
//
// Build option: define TM1638_ARB_KEY_SWITCH_EN to let a key-7 press force a
// handover to a waiting requester.
module tm1638_frame_arbiter #(
    parameter int unsigned HOLD_CYCLES     = 2500000,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic        clk_5MHz,
    input  logic        n_rst,
    input  logic        req_a,
    input  logic        req_b,
    input  logic [63:0] frame_a,
    input  logic [63:0] frame_b,
    input  logic [15:0] leds_a,
    input  logic [15:0] leds_b,
    input  logic [7:0]  keys_raw,
    output logic [63:0] digits,
    output logic [7:0]  leds_green,
    output logic [7:0]  leds_red,
    output logic        display_off,
    output logic [1:0]  grant,
    output logic [7:0]  keys_a_evt,
    output logic [7:0]  keys_b_evt
);

    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);

    // State encoding doubles as the registered grant vector.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            last_grant_q, last_grant_d;   // 0 = A, 1 = B
    logic            arm_q;                        // blocks a grant on the first edge after reset
    logic [7:0]      cand_q, cand_d;
    logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
    logic [7:0]      keys_stable_q, keys_stable_d;
    logic [7:0]      keys_stable_prev_q, keys_stable_prev_d;
    logic [7:0]      keys_a_evt_q, keys_a_evt_d;
    logic [7:0]      keys_b_evt_q, keys_b_evt_d;

    logic [7:0]      press_c;
    logic [7:0]      fwd_c;
    logic            other_req_c;
    logic            key_sw_c;

    // Key-press detection and the waiting-requester view of the owner.
    assign press_c = keys_stable_q & ~keys_stable_prev_q;

    always_comb begin
        other_req_c = 1'b0;
        case (state_q)
            OWN_A:   other_req_c = req_b;
            OWN_B:   other_req_c = req_a;
            default: other_req_c = 1'b0;
        endcase
    end

`ifdef TM1638_ARB_KEY_SWITCH_EN
    assign key_sw_c = press_c[7] & other_req_c;
`else
    assign key_sw_c = 1'b0;
`endif

    // Key 7 is swallowed when it triggers a handover.
    assign fwd_c = {press_c[7] & ~key_sw_c, press_c[6:0]};

    // Arbitration next-state, hold counter and last-grant tracking.
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (arm_q) begin
                    if (req_a && req_b) state_d = last_grant_q ? OWN_A : OWN_B;
                    else if (req_a)     state_d = OWN_A;
                    else if (req_b)     state_d = OWN_B;
                end
            end
            OWN_A: begin
                if (!req_a)                                              state_d = req_b ? OWN_B : IDLE;
                else if (other_req_c && (hold_cnt_q == HOLD_MAX || key_sw_c)) state_d = OWN_B;
            end
            OWN_B: begin
                if (!req_b)                                              state_d = req_a ? OWN_A : IDLE;
                else if (other_req_c && (hold_cnt_q == HOLD_MAX || key_sw_c)) state_d = OWN_A;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            hold_cnt_d = '0;
            if (state_d == OWN_A)      last_grant_d = 1'b0;
            else if (state_d == OWN_B) last_grant_d = 1'b1;
        end else if (state_q != IDLE && hold_cnt_q != HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
        end
    end

    // Debounce: accept the candidate once it has been steady long enough.
    always_comb begin
        cand_d             = keys_raw;
        deb_cnt_d          = deb_cnt_q;
        keys_stable_d      = keys_stable_q;
        keys_stable_prev_d = keys_stable_q;
        if (keys_raw != cand_q)       deb_cnt_d = '0;
        else if (deb_cnt_q != DEB_MAX) deb_cnt_d = deb_cnt_q + DW'(1);
        if (deb_cnt_q == DEB_MAX)     keys_stable_d = cand_q;
    end

    // Events go to the owner registered before the edge; dropped when idle.
    always_comb begin
        keys_a_evt_d = '0;
        keys_b_evt_d = '0;
        if (state_q == OWN_A)      keys_a_evt_d = fwd_c;
        else if (state_q == OWN_B) keys_b_evt_d = fwd_c;
    end

    always_ff @(posedge clk_5MHz or negedge n_rst) begin
        if (!n_rst) begin
            state_q            <= IDLE;
            hold_cnt_q         <= '0;
            last_grant_q       <= 1'b1;
            arm_q              <= 1'b0;
            cand_q             <= '0;
            deb_cnt_q          <= '0;
            keys_stable_q      <= '0;
            keys_stable_prev_q <= '0;
            keys_a_evt_q       <= '0;
            keys_b_evt_q       <= '0;
        end else begin
            state_q            <= state_d;
            hold_cnt_q         <= hold_cnt_d;
            last_grant_q       <= last_grant_d;
            arm_q              <= 1'b1;
            cand_q             <= cand_d;
            deb_cnt_q          <= deb_cnt_d;
            keys_stable_q      <= keys_stable_d;
            keys_stable_prev_q <= keys_stable_prev_d;
            keys_a_evt_q       <= keys_a_evt_d;
            keys_b_evt_q       <= keys_b_evt_d;
        end
    end

    // Display mux from the registered grant.
    always_comb begin
        digits      = '0;
        leds_green  = '0;
        leds_red    = '0;
        display_off = 1'b1;
        case (state_q)
            OWN_A: begin
                digits      = frame_a;
                leds_green  = leds_a[15:8];
                leds_red    = leds_a[7:0];
                display_off = 1'b0;
            end
            OWN_B: begin
                digits      = frame_b;
                leds_green  = leds_b[15:8];
                leds_red    = leds_b[7:0];
                display_off = 1'b0;
            end
            default: ;
        endcase
    end

    assign grant      = state_q;
    assign keys_a_evt = keys_a_evt_q;
    assign keys_b_evt = keys_b_evt_q;

endmodule
